// File: rtl/regbank_seq_pkg.sv
// Shared encodings for the register-bank micro-sequencer.
package regbank_seq_pkg;

  // Defaults shared with the 8x16 register bank
  localparam int W_DEF     = 16;
  localparam int N_SEL_DEF = 3;

  typedef enum logic [1:0] {
    OP_LDI  = 2'b00,
    OP_MOV  = 2'b01,
    OP_ADD  = 2'b10,
    OP_SWAP = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    WR1  = 3'd3,
    WR2  = 3'd4,
    DONE = 3'd5
  } state_t;

  // First sequence state for a freshly accepted command
  function automatic state_t first_state(input op_t o);
    return (o == OP_LDI) ? WR1 : RDA;
  endfunction

endpackage

// File: rtl/regbank_seq.sv
// Micro-sequencer: sole master of the register bank control pins.
// Runs one register-transfer command per start/done handshake.
module regbank_seq
  import regbank_seq_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int N_SEL = N_SEL_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [N_SEL-1:0] rd,
  input  logic [N_SEL-1:0] rs,
  input  logic [W-1:0]     imm,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic [N_SEL-1:0] rsel,
  output logic             wrr,
  output logic             tr,
  output logic [W-1:0]     wdata,
  input  logic [W-1:0]     bus
);

  state_t           state;
  op_t              op_q;
  logic [N_SEL-1:0] rd_q, rs_q;
  logic [W-1:0]     imm_q;
  logic [W-1:0]     ta, tb;
  logic [W:0]       sum;

  // Adder with carry-out; result only used in WR1 of ADD
  assign sum = {1'b0, ta} + {1'b0, tb};

  // Sequencer state, latched command fields, temporaries and carry
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      op_q  <= OP_LDI;
      rd_q  <= '0;
      rs_q  <= '0;
      imm_q <= '0;
      ta    <= '0;
      tb    <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q  <= op_t'(op);
          rd_q  <= rd;
          rs_q  <= rs;
          imm_q <= imm;
          state <= first_state(op_t'(op));
        end
        // Bus is only sampled here, so a floating bus elsewhere is harmless
        RDA: begin
          ta    <= bus;
          state <= (op_q == OP_MOV) ? WR1 : RDB;
        end
        RDB: begin
          tb    <= bus;
          state <= WR1;
        end
        WR1: begin
          if (op_q == OP_ADD) carry <= sum[W];
          state <= (op_q == OP_SWAP) ? WR2 : DONE;
        end
        WR2:     state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode of bank controls from state and latched fields
  always_comb begin
    rsel  = '0;
    wrr   = 1'b0;
    tr    = 1'b0;
    wdata = '0;
    busy  = (state != IDLE);
    done  = (state == DONE);
    case (state)
      RDA: begin
        rsel = rs_q;
        tr   = 1'b1;
      end
      RDB: begin
        rsel = rd_q;
        tr   = 1'b1;
      end
      WR1: begin
        rsel = rd_q;
        wrr  = 1'b1;
        case (op_q)
          OP_LDI:  wdata = imm_q;
          OP_ADD:  wdata = sum[W-1:0];
          default: wdata = ta;
        endcase
      end
      WR2: begin
        rsel  = rs_q;
        wrr   = 1'b1;
        wdata = tb;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regbank_seq.sv
// Directed bench for regbank_seq with a behavioural 8x16 bank on a shared bus.
module tb_regbank_seq;
  import regbank_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [2:0]  rd = '0, rs = '0;
  logic [15:0] imm = '0;
  logic        busy, done, carry, wrr, tr;
  logic [2:0]  rsel;
  logic [15:0] wdata;
  wire  [15:0] bus;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int wrr_cnt = 0;
  logic done_prev = 1'b0;

  logic [15:0] mem [8];

  always #5 clk = ~clk;

  regbank_seq #(.W(16), .N_SEL(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rd(rd), .rs(rs),
    .imm(imm), .busy(busy), .done(done), .carry(carry), .rsel(rsel),
    .wrr(wrr), .tr(tr), .wdata(wdata), .bus(bus)
  );

  // Register bank model: drives bus only while tr=1
  assign bus = tr ? mem[rsel] : 16'hzzzz;

  // Bank write port
  always @(posedge clk) if (wrr) mem[rsel] <= wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Every-cycle invariants plus event counters
  always @(negedge clk) begin
    if (reset) begin
      chk("wrr_tr_excl", {31'd0, wrr && tr}, 32'd0);
      chk("done_width", {31'd0, done && done_prev}, 32'd0);
      if (done) done_cnt++;
      if (wrr) wrr_cnt++;
    end
    done_prev <= done;
  end

  // Present a command at a negedge; returns in cycle k+1
  task automatic start_cmd(input logic [1:0] o, input logic [2:0] d, input logic [2:0] s,
                           input logic [15:0] i);
    op = o; rd = d; rs = s; imm = i; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; lat0 is the current cycle offset from k
  task automatic wait_done(input string tag, input int lat0, input int exp_lat);
    int lat = lat0;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk(tag, lat, exp_lat);
    @(negedge clk);
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [2:0] d,
                     input logic [2:0] s, input logic [15:0] i, input int exp_lat);
    start_cmd(o, d, s, i);
    wait_done(tag, 1, exp_lat);
  endtask

  initial begin
    int dc, wc;
    for (int j = 0; j < 8; j++) mem[j] = 16'h0;

    // Reset held 3 cycles
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ctl", {27'd0, wrr, tr, rsel}, 0);
    chk("rst_wdata", {16'd0, wdata}, 0);
    chk("rst_carry", {31'd0, carry}, 0);

    // LDI r0 = 8000 with in-cycle decode checks
    start_cmd(OP_LDI, 3'd0, 3'd0, 16'h8000);
    chk("ldi_k1", {12'd0, busy, wrr, tr, rsel, wdata}, {12'd0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h8000});
    wait_done("ldi_lat", 1, 2);
    chk("ldi_r0", {16'd0, mem[0]}, 32'h8000);

    // LDI r3 = FFFF, then MOV r5 <- r3
    run("ldi3_lat", OP_LDI, 3'd3, 3'd0, 16'hFFFF, 2);
    start_cmd(OP_MOV, 3'd5, 3'd3, 16'h0);
    chk("mov_k1", {27'd0, wrr, tr, rsel}, {27'd0, 1'b0, 1'b1, 3'd3});
    chk("mov_k1_bus", {16'd0, bus}, 32'hFFFF);
    @(negedge clk);
    chk("mov_k2", {11'd0, wrr, tr, rsel, wdata}, {11'd0, 1'b1, 1'b0, 3'd5, 16'hFFFF});
    wait_done("mov_lat", 2, 3);
    chk("mov_r5", {16'd0, mem[5]}, 32'hFFFF);

    // ADD with wrap and carry, then rd==rs ADD doubling zero
    run("ldi1_lat", OP_LDI, 3'd1, 3'd0, 16'hFFFF, 2);
    run("ldi2_lat", OP_LDI, 3'd2, 3'd0, 16'h0001, 2);
    run("add_lat", OP_ADD, 3'd2, 3'd1, 16'h0, 4);
    chk("add_r2", {16'd0, mem[2]}, 32'h0000);
    chk("add_carry", {31'd0, carry}, 1);
    run("add2_lat", OP_ADD, 3'd2, 3'd2, 16'h0, 4);
    chk("add2_r2", {16'd0, mem[2]}, 32'h0000);
    chk("add2_carry", {31'd0, carry}, 0);
    // rd==rs doubling of a nonzero value: 4001+4001 = 8002
    run("ldi7_lat", OP_LDI, 3'd7, 3'd0, 16'h4001, 2);
    run("add3_lat", OP_ADD, 3'd7, 3'd7, 16'h0, 4);
    chk("add3_r7", {16'd0, mem[7]}, 32'h8002);

    // SWAP, then SWAP with rd==rs
    run("ldi4_lat", OP_LDI, 3'd4, 3'd0, 16'h1234, 2);
    run("ldi6_lat", OP_LDI, 3'd6, 3'd0, 16'hABCD, 2);
    run("swap_lat", OP_SWAP, 3'd4, 3'd6, 16'h0, 5);
    chk("swap_r4", {16'd0, mem[4]}, 32'hABCD);
    chk("swap_r6", {16'd0, mem[6]}, 32'h1234);
    run("swap2_lat", OP_SWAP, 3'd4, 3'd4, 16'h0, 5);
    chk("swap2_r4", {16'd0, mem[4]}, 32'hABCD);
    chk("carry_held", {31'd0, carry}, 0);

    // start pulsed mid-MOV is ignored
    dc = done_cnt; wc = wrr_cnt;
    start_cmd(OP_MOV, 3'd7, 3'd3, 16'h0);
    op = OP_LDI; rd = 3'd0; imm = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign_lat", 2, 3);
    repeat (3) @(negedge clk);
    chk("ign_dones", done_cnt - dc, 1);
    chk("ign_wrr", wrr_cnt - wc, 1);
    chk("ign_r7", {16'd0, mem[7]}, 32'hFFFF);
    chk("ign_r0", {16'd0, mem[0]}, 32'h8000);

    // Reset during RDB of ADD aborts without a write
    dc = done_cnt;
    start_cmd(OP_ADD, 3'd1, 3'd6, 16'h0);
    @(negedge clk);
    chk("abort_in_rdb", {30'd0, tr, busy}, 3);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ctl", {29'd0, wrr, busy, tr}, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_r1", {16'd0, mem[1]}, 32'hFFFF);
    chk("abort_done", done_cnt - dc, 0);
    chk("abort_busy", {31'd0, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
